weight_fetch_ctrl: RTL and testbench



---
 rtl/ann_pkg.sv | 15 +
 rtl/weight_out_stage.sv | 35 +++
 rtl/weight_fetch_ctrl.sv | 122 ++++++++++++
 tb/tb_weight_fetch_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ann_pkg.sv
// Shared types and default geometry for the ANN weight path.
package ann_pkg;

    localparam int unsigned DefDepth = 28;
    localparam int unsigned DefAw    = 5;
    localparam int unsigned DefDw    = 16;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StFetch,
        StDrain
    } wf_state_e;

endpackage

// File: rtl/weight_out_stage.sv
// Registered weight output stage: holds a BRAM read word until the MAC accepts it.
module weight_out_stage #(
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rd_req,
    input  logic          rd_last,
    input  logic [DW-1:0] mem_do,
    input  logic          w_ready,
    output logic          rd_issue,
    output logic [DW-1:0] w_data,
    output logic          w_valid,
    output logic          w_last
);

    // A new read may only land when the held word is absent or leaving this cycle.
    assign rd_issue = rd_req && (!w_valid || w_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_data  <= '0;
            w_valid <= 1'b0;
            w_last  <= 1'b0;
        end else if (rd_issue) begin
            w_data  <= mem_do;
            w_valid <= 1'b1;
            w_last  <= rd_last;
        end else if (w_ready) begin
            w_valid <= 1'b0;
            w_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Weight BRAM controller: loads DEPTH words from a stream and replays them to the MAC.
module weight_fetch_ctrl
    import ann_pkg::*;
#(
    parameter int unsigned DEPTH = DefDepth,
    parameter int unsigned AW    = DefAw,
    parameter int unsigned DW    = DefDw
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          START_LOAD,
    input  logic          START_FETCH,
    input  logic [DW-1:0] L_DATA,
    input  logic          L_VALID,
    output logic          L_READY,
    output logic [DW-1:0] W_DATA,
    output logic          W_VALID,
    output logic          W_LAST,
    input  logic          W_READY,
    output logic [AW-1:0] MEM_ADDR,
    output logic [DW-1:0] MEM_DI,
    output logic          MEM_EN,
    output logic          MEM_WE,
    input  logic [DW-1:0] MEM_DO,
    output logic          BUSY,
    output logic          DONE
);

    localparam logic [AW:0] CntLast  = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0] CntDepth = (AW + 1)'(DEPTH);

    wf_state_e   state_q, state_d;
    logic [AW:0] cnt_q, cnt_d;
    logic        done_q, done_d;

    logic wr_fire;
    logic rd_req;
    logic rd_issue;
    logic w_hs;

    assign wr_fire = (state_q == StLoad) && L_VALID;
    assign rd_req  = (state_q == StFetch) && (cnt_q < CntDepth);
    assign w_hs    = W_VALID && W_READY;

    assign L_READY = (state_q == StLoad);
    assign BUSY    = (state_q != StIdle);
    // Load completion is registered; fetch completion coincides with the last handshake.
    assign DONE    = done_q || ((state_q == StDrain) && w_hs && W_LAST);

    assign MEM_EN   = wr_fire || rd_issue;
    assign MEM_WE   = wr_fire;
    assign MEM_ADDR = MEM_EN ? cnt_q[AW-1:0] : '0;
    assign MEM_DI   = wr_fire ? L_DATA : '0;

    weight_out_stage #(
        .DW(DW)
    ) u_out_stage (
        .clk     (CLK),
        .rst_n   (RST_N),
        .rd_req  (rd_req),
        .rd_last (cnt_q == CntLast),
        .mem_do  (MEM_DO),
        .w_ready (W_READY),
        .rd_issue(rd_issue),
        .w_data  (W_DATA),
        .w_valid (W_VALID),
        .w_last  (W_LAST)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (START_LOAD) begin
                    state_d = StLoad;
                    cnt_d   = '0;
                end else if (START_FETCH) begin
                    state_d = StFetch;
                    cnt_d   = '0;
                end
            end
            StLoad: begin
                if (wr_fire) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            StFetch: begin
                if (rd_issue) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (w_hs && W_LAST) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Randomized self-checking bench for weight_fetch_ctrl with a transaction-level model.
module tb_weight_fetch_ctrl;

    localparam int DEPTH = 28;
    localparam int AW    = 5;
    localparam int DW    = 16;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b1;
    logic          START_LOAD = 1'b0;
    logic          START_FETCH = 1'b0;
    logic [DW-1:0] L_DATA = '0;
    logic          L_VALID = 1'b0;
    logic          L_READY;
    logic [DW-1:0] W_DATA;
    logic          W_VALID;
    logic          W_LAST;
    logic          W_READY = 1'b0;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_DI;
    logic          MEM_EN;
    logic          MEM_WE;
    logic [DW-1:0] MEM_DO = '0;
    logic          BUSY;
    logic          DONE;

    weight_fetch_ctrl #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .START_LOAD (START_LOAD),
        .START_FETCH(START_FETCH),
        .L_DATA     (L_DATA),
        .L_VALID    (L_VALID),
        .L_READY    (L_READY),
        .W_DATA     (W_DATA),
        .W_VALID    (W_VALID),
        .W_LAST     (W_LAST),
        .W_READY    (W_READY),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_DI     (MEM_DI),
        .MEM_EN     (MEM_EN),
        .MEM_WE     (MEM_WE),
        .MEM_DO     (MEM_DO),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // BRAM: registers read data (and performs writes) on the falling edge.
    logic [DW-1:0] bram [0:31];
    always @(negedge CLK) begin
        if (MEM_EN) begin
            if (MEM_WE) bram[MEM_ADDR] <= MEM_DI;
            else        MEM_DO <= bram[MEM_ADDR];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: phase 0 idle, 1 loading, 2 fetching (including drain).
    int            mphase = 0;
    int            wr_n = 0;
    int            rd_n = 0;
    int            hs_n = 0;
    bit            done_due = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    logic [DW-1:0] model_mem [0:DEPTH-1];
    logic [DW-1:0] got [0:DEPTH-1];
    int            first_issue_cyc = 0;
    int            last_hs_cyc = 0;
    int            done_cyc = 0;

    int  ph;
    bit  hs, stall, exp_issue, exp_done;

    initial begin
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                check("rst_w_valid", W_VALID, 0);
                check("rst_mem_en", MEM_EN, 0);
                check("rst_busy", BUSY, 0);
                check("rst_done", DONE, 0);
                check("rst_l_ready", L_READY, 0);
                check("rst_w_data", W_DATA, 0);
                mphase = 0;
                done_due = 0;
                prev_stall = 0;
            end else begin
                ph = mphase;
                hs = W_VALID && W_READY;
                check("busy", BUSY, ph != 0);
                check("l_ready", L_READY, ph == 1);
                exp_done = done_due || (ph == 2 && hs && hs_n == DEPTH - 1);
                check("done", DONE, exp_done);
                if (DONE) done_cyc = cyc;
                done_due = 0;
                if (ph == 1) begin
                    check("load_mem_en", MEM_EN, L_VALID);
                    check("load_mem_we", MEM_WE, L_VALID);
                    check("load_w_valid", W_VALID, 0);
                    if (L_VALID) begin
                        check("load_addr", MEM_ADDR, wr_n);
                        check("load_di", MEM_DI, L_DATA);
                        model_mem[wr_n] = L_DATA;
                        if (wr_n == DEPTH - 1) begin
                            mphase = 0;
                            done_due = 1;
                        end
                        wr_n++;
                    end
                    prev_stall = 0;
                end else if (ph == 2) begin
                    stall = W_VALID && !W_READY;
                    exp_issue = (rd_n < DEPTH) && !stall;
                    check("w_valid", W_VALID, rd_n > hs_n);
                    check("fetch_mem_en", MEM_EN, exp_issue);
                    check("fetch_mem_we", MEM_WE, 0);
                    if (exp_issue) begin
                        check("fetch_addr", MEM_ADDR, rd_n);
                        if (rd_n == 0) first_issue_cyc = cyc;
                        rd_n++;
                    end
                    if (prev_stall) begin
                        check("stall_data", W_DATA, prev_data);
                        check("stall_last", W_LAST, prev_last);
                    end
                    if (hs) begin
                        check("w_data", W_DATA, model_mem[hs_n]);
                        check("w_last", W_LAST, hs_n == DEPTH - 1);
                        got[hs_n] = W_DATA;
                        last_hs_cyc = cyc;
                        if (hs_n == DEPTH - 1) mphase = 0;
                        hs_n++;
                    end
                    prev_stall = stall;
                    prev_data = W_DATA;
                    prev_last = W_LAST;
                end else begin
                    check("idle_mem_en", MEM_EN, 0);
                    check("idle_w_valid", W_VALID, 0);
                    prev_stall = 0;
                end
                if (ph == 0) begin
                    if (START_LOAD) begin
                        mphase = 1;
                        wr_n = 0;
                    end else if (START_FETCH) begin
                        mphase = 2;
                        rd_n = 0;
                        hs_n = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_load(input int gap_mode, input bit both_starts, input bit rand_data);
        int i;
        int t;
        i = 0;
        t = 0;
        START_LOAD = 1'b1;
        START_FETCH = both_starts;
        tick();
        START_LOAD = 1'b0;
        START_FETCH = 1'b0;
        check("load_started", L_READY, 1);
        while (i < DEPTH && t < 400) begin
            case (gap_mode)
                0: L_VALID = 1'b1;
                1: L_VALID = !((t % 5) == 1 || (t % 5) == 4);
                default: L_VALID = 1'($urandom_range(0, 1));
            endcase
            L_DATA = rand_data ? 16'($urandom) : 16'(i);
            @(negedge CLK);
            if (L_VALID && L_READY) i++;
            tick();
            t++;
        end
        L_VALID = 1'b0;
        if (t >= 400) check("load_timeout", i, DEPTH);
        repeat (3) tick();
    endtask

    task automatic do_fetch(input int rdy_mode, input int restart_at, input int abort_at);
        int  t;
        int  n;
        bit  fin;
        t = 0;
        n = 0;
        fin = 0;
        START_FETCH = 1'b1;
        tick();
        START_FETCH = 1'b0;
        check("fetch_started", BUSY, 1);
        while (!fin && t < 400) begin
            case (rdy_mode)
                0: W_READY = 1'b1;
                1: W_READY = (t % 3) == 0;
                default: W_READY = 1'($urandom_range(0, 1));
            endcase
            START_FETCH = (t == restart_at);
            @(negedge CLK);
            if (W_VALID && W_READY) n++;
            if (DONE) fin = 1;
            if (abort_at > 0 && n == abort_at) begin
                @(posedge CLK);
                #2;
                check("pre_reset_w_valid", W_VALID, 1);
                RST_N = 1'b0;
                #1;
                check("abort_w_valid", W_VALID, 0);
                check("abort_mem_en", MEM_EN, 0);
                check("abort_busy", BUSY, 0);
                fin = 1;
                repeat (2) tick();
                RST_N = 1'b1;
            end else begin
                tick();
            end
            t++;
        end
        START_FETCH = 1'b0;
        W_READY = 1'b0;
        if (!fin) check("fetch_timeout", fin, 1);
        if (abort_at == 0) repeat (2) tick();
    endtask

    initial begin
        #1;
        RST_N = 1'b0;
        #1;
        check("init_w_valid", W_VALID, 0);
        check("init_w_last", W_LAST, 0);
        check("init_w_data", W_DATA, 0);
        check("init_l_ready", L_READY, 0);
        check("init_busy", BUSY, 0);
        check("init_done", DONE, 0);
        check("init_mem_en", MEM_EN, 0);
        check("init_mem_we", MEM_WE, 0);
        check("init_mem_addr", MEM_ADDR, 0);
        check("init_mem_di", MEM_DI, 0);
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1'b1;

        // Directed load of 0..27 followed by a full-rate fetch.
        do_load(0, 0, 0);
        check("pin_mem0", model_mem[0], 16'h0000);
        check("pin_mem27", model_mem[27], 16'h001B);
        check("load_busy_after", BUSY, 0);
        check("load_l_ready_after", L_READY, 0);
        do_fetch(0, -1, 0);
        check("pin_got0", got[0], 16'h0000);
        check("pin_got13", got[13], 16'h000D);
        check("pin_got27", got[27], 16'h001B);
        check("throughput", last_hs_cyc - first_issue_cyc, DEPTH);
        check("done_at_last", done_cyc, last_hs_cyc);
        check("words_fullrate", hs_n, DEPTH);

        // Stalling consumer with a spurious START_FETCH mid-stream.
        do_fetch(1, 5, 0);
        check("words_stall", hs_n, DEPTH);
        check("pin_got27_stall", got[27], 16'h001B);

        // Simultaneous starts with gapped random data.
        do_load(1, 1, 1);
        do_fetch(2, -1, 0);
        check("words_rand", hs_n, DEPTH);

        // Reset after ten words, then a fresh fetch from address 0.
        do_fetch(0, -1, 10);
        do_fetch(0, -1, 0);
        check("words_after_abort", hs_n, DEPTH);
        check("first_after_abort", got[0], model_mem[0]);

        for (int k = 0; k < 4; k++) begin
            do_load(2, 0, 1);
            do_fetch(2, int'($urandom_range(0, 40)), 0);
            check("words_loop", hs_n, DEPTH);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
